// File: rtl/nibble_serial_cla_adder_pkg.sv
// Shared types and constants for the nibble-serial CLA adder/subtractor.
package nibble_serial_cla_adder_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_cla_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice: per-bit p/g cells plus lookahead carry unit.
module nibble_serial_cla_adder_cla4_slice
  import nibble_serial_cla_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] s,
  output logic [SLICE_W-1:0] carry,
  output logic               c_out,
  output logic               p_grp,
  output logic               g_grp
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;

  assign p = a ^ b;
  assign g = a & b;

  // carry[i] is the carry into bit i, all computed directly from p/g and c_in
  always_comb begin
    carry[0] = c_in;
    carry[1] = g[0] | (p[0] & c_in);
    carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  end

  assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_grp = &p;
  assign c_out = g_grp | (p_grp & c_in);
  assign s     = p ^ carry;

endmodule

// File: rtl/nibble_serial_cla_adder.sv
// WIDTH-bit adder/subtractor that pushes one nibble per cycle through a shared 4-bit CLA slice.
module nibble_serial_cla_adder
  import nibble_serial_cla_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned N_NIB = WIDTH / SLICE_W;
  localparam int unsigned IDX_W = $clog2(N_NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

  state_t state, state_nxt;
  logic accept, step, last;

  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_s, sl_carry;
  logic               sl_cout, sl_p, sl_g;

  assign sl_a = a_q[int'(idx) * SLICE_W +: SLICE_W];
  assign sl_b = b_q[int'(idx) * SLICE_W +: SLICE_W];

  nibble_serial_cla_adder_cla4_slice u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .c_in  (carry_q),
    .s     (sl_s),
    .carry (sl_carry),
    .c_out (sl_cout),
    .p_grp (sl_p),
    .g_grp (sl_g)
  );

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        last = (idx == LAST_IDX);
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, handshake flags and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx      <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_RUN);
      done  <= (state_nxt == S_DONE);
      if (accept) begin
        a_q     <= a;
        b_q     <= b ^ {WIDTH{op_sub}};
        carry_q <= op_sub | c_in;
        idx     <= '0;
        sum     <= '0;
      end
      if (step) begin
        sum[int'(idx) * SLICE_W +: SLICE_W] <= sl_s;
        carry_q <= sl_g | (sl_p & carry_q);
        idx     <= last ? '0 : idx + IDX_W'(1);
        if (last) begin
          c_out    <= sl_cout;
          overflow <= sl_carry[SLICE_W-1] ^ sl_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Self-checking bench: directed vectors, handshake/reset corner cases, random ops vs arithmetic model.
module tb_nibble_serial_cla_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst, start, op_sub, c_in;
  logic [W-1:0] a, b, sum;
  logic         busy, done, c_out, overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_cla_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  typedef struct {
    logic         sub;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Two's-complement arithmetic reference
  function automatic void model(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic ci, output logic [W-1:0] s, output logic co,
                                output logic ov);
    logic [W:0]   full;
    logic [W-1:0] yy;
    logic         cc;
    yy   = sub ? ~y : y;
    cc   = sub ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + (W+1)'(cc);
    s    = full[W-1:0];
    co   = full[W];
    ov   = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Present an op at a negedge; returns #1 after the accept edge (cycle T+1) with garbage on inputs
  task automatic issue(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    @(negedge clk);
    start = 1'b1; op_sub = sub; a = x; b = y; c_in = ci;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); op_sub = 1'($urandom);
  endtask

  task automatic wait_done(inout int n);
    while (done !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string name, input int n, input logic [W-1:0] es,
                              input logic eco, input logic eov);
    chk({name, "_latency"}, 32'(n), 32'd5);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_c_out"}, 32'(c_out), 32'(eco));
    chk({name, "_overflow"}, 32'(overflow), 32'(eov));
  endtask

  task automatic run_model(input string name, input logic sub, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic ci);
    logic [W-1:0] es;
    logic eco, eov;
    int n;
    model(sub, x, y, ci, es, eco, eov);
    issue(sub, x, y, ci);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    n = 1;
    wait_done(n);
    check_result(name, n, es, eco, eov);
  endtask

  initial begin
    int n, done_seen;
    logic [W-1:0] es;
    logic eco, eov;

    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_c_out", 32'(c_out), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].sub, vecs[i].x, vecs[i].y, vecs[i].ci);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      n = 1;
      wait_done(n);
      check_result($sformatf("vec%0d", i), n, vecs[i].s, vecs[i].co, vecs[i].ov);
    end

    // Start pulsed while busy is ignored; start during done is accepted back-to-back
    @(negedge clk);
    issue(1'b0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; op_sub = 1'b0; a = 16'hAAAA; b = 16'h5555; c_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    wait_done(n);
    check_result("ignore_busy_start", n, 16'h3333, 1'b0, 1'b0);
    start = 1'b1; op_sub = 1'b1; a = 16'h8000; b = 16'h0001; c_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    n = 1;
    wait_done(n);
    check_result("b2b", n, 16'h7FFF, 1'b1, 1'b1);

    // Reset in T+2 aborts the op; outputs (c_out=1 beforehand) return to zero
    run_model("pre_reset", 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_c_out", 32'(c_out), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    done_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    run_model("post_reset", 1'b0, 16'h1234, 16'h4321, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic         rs, rc;
      logic [W-1:0] rx, ry;
      rs = 1'($urandom); rc = 1'($urandom);
      rx = W'($urandom); ry = W'($urandom);
      if (i % 8 == 0) ry = rx;
      run_model($sformatf("rand%0d", i), rs, rx, ry, rc);
    end

    // Sanity of the model itself against the directed table
    for (int i = 0; i < 6; i++) begin
      model(vecs[i].sub, vecs[i].x, vecs[i].y, vecs[i].ci, es, eco, eov);
      chk($sformatf("model_vec%0d", i), 32'({es, eco, eov}), 32'({vecs[i].s, vecs[i].co, vecs[i].ov}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
